// File: rtl/reg_wb_queue.sv
// Writeback queue for the register file: arbitrates ALU and LSU results,
// buffers them in a circular FIFO, drains one write per cycle and offers
// forwarding of queued-but-unwritten results to the decode stage.

// Per-entry forwarding match: one instance per FIFO slot.
module reg_wb_fwd_slot (
    input  logic       vld,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       hit1,
    output logic       hit2
);
    // x0 is hardwired zero, so it never forwards
    assign hit1 = vld && (rd == rs1) && (rs1 != 5'd0);
    assign hit2 = vld && (rd == rs2) && (rs2 != 5'd0);
endmodule

module reg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_alu_valid,
    output logic            o_alu_ready,
    input  logic [4:0]      i_alu_rd,
    input  logic [XLEN-1:0] i_alu_data,
    input  logic            i_lsu_valid,
    output logic            o_lsu_ready,
    input  logic [4:0]      i_lsu_rd,
    input  logic [XLEN-1:0] i_lsu_data,
    output logic            o_wr,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_write_data,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    output logic            o_fwd1_hit,
    output logic            o_fwd2_hit,
    output logic [XLEN-1:0] o_fwd1_data,
    output logic [XLEN-1:0] o_fwd2_data,
    output logic            o_pending
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    wb_entry_t [DEPTH-1:0] mem;
    wb_entry_t             alu_req, lsu_req, push_req, head;

    logic [PW-1:0] wr_ptr, rd_ptr, idx;
    logic [PW:0]   count;
    logic          prio_lsu;
    logic          full, grant_alu, grant_lsu, xfer_alu, xfer_lsu, push, pop;
    logic [DEPTH-1:0] slot_vld, slot_hit1, slot_hit2;

    assign alu_req = '{rd: i_alu_rd, data: i_alu_data};
    assign lsu_req = '{rd: i_lsu_rd, data: i_lsu_data};

    // Round-robin grant: a lone requester always wins, otherwise prio_lsu decides
    always_comb begin
        grant_lsu = i_lsu_valid && (prio_lsu || !i_alu_valid);
        grant_alu = i_alu_valid && (!prio_lsu || !i_lsu_valid);
    end

    // Full blocks both sources; a same-cycle pop earns no credit
    assign full        = (count == FULL_CNT);
    assign o_alu_ready = grant_alu && !full;
    assign o_lsu_ready = grant_lsu && !full;
    assign xfer_alu    = i_alu_valid && o_alu_ready;
    assign xfer_lsu    = i_lsu_valid && o_lsu_ready;

    // Writes to x0 are accepted and dropped without occupying a slot
    assign push_req = xfer_lsu ? lsu_req : alu_req;
    assign push     = (xfer_alu || xfer_lsu) && (push_req.rd != 5'd0);
    assign pop      = (count != '0);
    assign head     = mem[rd_ptr];

    // Priority flips to the other source after every accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_lsu <= 1'b1;
        end else if (xfer_lsu) begin
            prio_lsu <= 1'b0;
        end else if (xfer_alu) begin
            prio_lsu <= 1'b1;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: slots are only read when counted valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_req;
    end

    // Register-file write port; index/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_wr         <= 1'b0;
            o_rd         <= '0;
            o_write_data <= '0;
        end else begin
            o_wr <= pop;
            if (pop) begin
                o_rd         <= head.rd;
                o_write_data <= head.data;
            end
        end
    end

    assign o_pending = (count != '0) || o_wr;

    // A slot is live when its distance from the head is below count
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PW-1:0] age;
        assign age         = PW'(i) - rd_ptr;
        assign slot_vld[i] = ({1'b0, age} < count);
        reg_wb_fwd_slot u_slot (
            .vld  (slot_vld[i]),
            .rd   (mem[i].rd),
            .rs1  (i_rs1),
            .rs2  (i_rs2),
            .hit1 (slot_hit1[i]),
            .hit2 (slot_hit2[i])
        );
    end

    // Forward select: output register is oldest, then walk head to tail so newest wins
    always_comb begin
        o_fwd1_hit  = 1'b0;
        o_fwd1_data = '0;
        o_fwd2_hit  = 1'b0;
        o_fwd2_data = '0;
        idx         = '0;
        if (o_wr && (o_rd == i_rs1) && (i_rs1 != 5'd0)) begin
            o_fwd1_hit  = 1'b1;
            o_fwd1_data = o_write_data;
        end
        if (o_wr && (o_rd == i_rs2) && (i_rs2 != 5'd0)) begin
            o_fwd2_hit  = 1'b1;
            o_fwd2_data = o_write_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (slot_hit1[idx]) begin
                o_fwd1_hit  = 1'b1;
                o_fwd1_data = mem[idx].data;
            end
            if (slot_hit2[idx]) begin
                o_fwd2_hit  = 1'b1;
                o_fwd2_data = mem[idx].data;
            end
        end
    end
endmodule
